core_bus_arb: RTL and testbench

- Two-requester Avalon-MM arbiter that lets the core's instruction-fetch master and data-access master share one downstream memory port.
- Sits between the core's two bus masters and a single-ported memory/interconnect slave.
- Tracks outstanding pipelined reads so each returned read word is routed back to the requester that issued it.

---
 rtl/core_bus_arb.sv | 126 ++++++++++++
 tb/tb_core_bus_arb.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arb.sv
// core_bus_arb: two-master Avalon-MM arbiter sharing one downstream port, with
// in-order read-return routing. Define CORE_BUS_ARB_RR_EN for round-robin arbitration.
module core_bus_arb #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rest,
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic [DATA_W/8-1:0] s0_byte_en,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W-1:0]   s0_write_data,
  output logic [DATA_W-1:0]   s0_read_data,
  output logic                s0_read_data_valid,
  output logic                s0_waitrequest,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byte_en,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_write_data,
  output logic [DATA_W-1:0]   s1_read_data,
  output logic                s1_read_data_valid,
  output logic                s1_waitrequest,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byte_en,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_write_data,
  input  logic [DATA_W-1:0]   m_read_data,
  input  logic                m_read_data_valid,
  input  logic                m_waitrequest
);
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t state, state_nxt;

  logic             s0_act, s1_act, idle_sel, sel;
  logic             gnt_act, g_write, g_read, gnt_wait, accepted, fifo_full;
  logic             push, pop, head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             tag_mem [MAX_OUTSTANDING];

  assign s0_act    = s0_read | s0_write;
  assign s1_act    = s1_read | s1_write;
  // A same-cycle return frees a slot, so a full FIFO can still take a read.
  assign fifo_full = (count == CNT_W'(MAX_OUTSTANDING)) & ~m_read_data_valid;

`ifdef CORE_BUS_ARB_RR_EN
  logic last_gnt;
  assign idle_sel = (s0_act & s1_act) ? ~last_gnt : s1_act;

  always_ff @(posedge clk or posedge rest) begin
    if (rest)          last_gnt <= 1'b0;
    else if (accepted) last_gnt <= sel;
  end
`else
  assign idle_sel = s1_act;
`endif

  always_ff @(posedge clk or posedge rest) begin
    if (rest) state <= IDLE;
    else      state <= state_nxt;
  end

  // Grant selection, acceptance and next-state.
  always_comb begin
    state_nxt = state;
    sel       = 1'b0;
    case (state)
      IDLE:    sel = idle_sel;
      LOCK0:   sel = 1'b0;
      LOCK1:   sel = 1'b1;
      default: sel = 1'b0;
    endcase
    gnt_act  = sel ? s1_act : s0_act;
    g_write  = sel ? s1_write : s0_write;
    g_read   = (sel ? s1_read : s0_read) & ~g_write;
    gnt_wait = m_waitrequest | (g_read & fifo_full);
    accepted = gnt_act & ~rest & ~gnt_wait;
    case (state)
      IDLE:         if (gnt_act & ~accepted) state_nxt = sel ? LOCK1 : LOCK0;
      LOCK0, LOCK1: if (accepted) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  assign m_address      = sel ? s1_address : s0_address;
  assign m_byte_en      = sel ? s1_byte_en : s0_byte_en;
  assign m_write_data   = sel ? s1_write_data : s0_write_data;
  assign m_read         = gnt_act & g_read & ~fifo_full & ~rest;
  assign m_write        = gnt_act & g_write & ~rest;
  assign s0_waitrequest = s0_act & (sel ? 1'b1 : gnt_wait);
  assign s1_waitrequest = s1_act & (sel ? gnt_wait : 1'b1);

  // Read-return tag FIFO; returns with nothing outstanding are dropped.
  assign push               = m_read & ~m_waitrequest;
  assign pop                = m_read_data_valid & (count != '0);
  assign head               = tag_mem[rd_ptr];
  assign s0_read_data_valid = pop & ~head;
  assign s1_read_data_valid = pop & head;
  assign s0_read_data       = m_read_data;
  assign s1_read_data       = m_read_data;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push & ~pop)      count <= count + CNT_W'(1);
      else if (pop & ~push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_core_bus_arb.sv
// tb_core_bus_arb: directed scenarios plus a randomized run checked by a
// transfer/return scoreboard fed from a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_core_bus_arb;
  localparam int unsigned MAXO = 4;

  logic        clk = 1'b0;
  logic        rest;
  logic [31:0] s0_address, s1_address, m_address;
  logic [3:0]  s0_byte_en, s1_byte_en, m_byte_en;
  logic        s0_read, s0_write, s1_read, s1_write, m_read, m_write;
  logic [31:0] s0_write_data, s1_write_data, m_write_data;
  logic [31:0] s0_read_data, s1_read_data, m_read_data;
  logic        s0_read_data_valid, s1_read_data_valid, m_read_data_valid;
  logic        s0_waitrequest, s1_waitrequest, m_waitrequest;

  core_bus_arb #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rest(rest),
    .s0_address(s0_address), .s0_byte_en(s0_byte_en), .s0_read(s0_read),
    .s0_write(s0_write), .s0_write_data(s0_write_data), .s0_read_data(s0_read_data),
    .s0_read_data_valid(s0_read_data_valid), .s0_waitrequest(s0_waitrequest),
    .s1_address(s1_address), .s1_byte_en(s1_byte_en), .s1_read(s1_read),
    .s1_write(s1_write), .s1_write_data(s1_write_data), .s1_read_data(s1_read_data),
    .s1_read_data_valid(s1_read_data_valid), .s1_waitrequest(s1_waitrequest),
    .m_address(m_address), .m_byte_en(m_byte_en), .m_read(m_read), .m_write(m_write),
    .m_write_data(m_write_data), .m_read_data(m_read_data),
    .m_read_data_valid(m_read_data_valid), .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } xfer_t;

  int          vectors = 0;
  int          miscompares = 0;
  xfer_t       mq[$];
  logic [31:0] rq0[$], rq1[$];
  logic [31:0] pend[$];
  int          acc_cnt = 0;
  int          out_cnt = 0;
  bit          mem_on = 1'b0;
  bit          mon_on = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event-missing, expected event", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    if (n == 0) begin
      s0_read = rd; s0_write = wr; s0_address = a; s0_write_data = d; s0_byte_en = be;
    end else begin
      s1_read = rd; s1_write = wr; s1_address = a; s1_write_data = d; s1_byte_en = be;
    end
  endtask

  // One randomized requester: holds each request until its waitrequest is seen low.
  task automatic driver(input int n, input int count);
    int          gap, op, waited;
    logic        rd, wr, done, wreq;
    logic [31:0] a, d;
    logic [3:0]  be;
    for (int t = 0; t < count; t++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) cyc();
      op = $urandom_range(0, 19);
      rd = (op < 12) || (op == 19);
      wr = (op >= 12);
      a  = $urandom;
      d  = $urandom;
      be = 4'($urandom);
      set_req(n, rd, wr, a, d, be);
      waited = 0;
      done   = 1'b0;
      while (!done) begin
        smp();
        wreq = (n != 0) ? s1_waitrequest : s0_waitrequest;
        if (!wreq) begin
          done = 1'b1;
          acc_cnt++;
          mq.push_back('{wr: wr, addr: a, data: d, be: be});
          if (!wr) begin
            if (n == 0) rq0.push_back(mem_word(a));
            else        rq1.push_back(mem_word(a));
          end
        end else if (++waited > 200) begin
          fail_now("request_timeout");
          done = 1'b1;
        end
        cyc();
      end
      set_req(n, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
  endtask

  // Downstream slave: random stalls, in-order returns with random latency.
  task automatic memory();
    while (mem_on) begin
      m_waitrequest = ($urandom_range(0, 3) == 0);
      out_cnt       = pend.size();
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        m_read_data_valid = 1'b1;
        m_read_data       = mem_word(pend.pop_front());
      end else begin
        m_read_data_valid = 1'b0;
        m_read_data       = $urandom;
      end
      smp();
      if (m_read && !m_waitrequest) pend.push_back(m_address);
      cyc();
    end
    m_read_data_valid = 1'b0;
    m_waitrequest     = 1'b0;
  endtask

  task automatic monitor();
    xfer_t x;
    while (mon_on) begin
      smp();
      #1;
      check("single_accept_per_cycle", 64'(acc_cnt > 1), 64'(0));
      acc_cnt = 0;
      if (out_cnt == MAXO && !m_read_data_valid) check("m_read_gated_full", 64'(m_read), 64'(0));
      if ((m_read || m_write) && !m_waitrequest) begin
        if (mq.size() == 0) fail_now("unexpected_downstream_xfer");
        else begin
          x = mq.pop_front();
          check("xfer_kind", 64'({m_write, m_read}), 64'({x.wr, ~x.wr}));
          check("xfer_addr", 64'(m_address), 64'(x.addr));
          check("xfer_be", 64'(m_byte_en), 64'(x.be));
          if (x.wr) check("xfer_wdata", 64'(m_write_data), 64'(x.data));
        end
      end
      if (m_read_data_valid) begin
        check("return_routed_once", 64'({s0_read_data_valid, s1_read_data_valid} != 2'b00 &&
              {s0_read_data_valid, s1_read_data_valid} != 2'b11), 64'(1));
      end
      if (s0_read_data_valid) begin
        if (rq0.size() == 0) fail_now("s0_unexpected_return");
        else check("s0_read_data", 64'(s0_read_data), 64'(rq0.pop_front()));
      end
      if (s1_read_data_valid) begin
        if (rq1.size() == 0) fail_now("s1_unexpected_return");
        else check("s1_read_data", 64'(s1_read_data), 64'(rq1.pop_front()));
      end
    end
  endtask

  initial begin
    logic exp_s1;
    int   waited;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    m_read_data = 32'h0; m_read_data_valid = 1'b0; m_waitrequest = 1'b0;
    rest = 1'b1;

    // Reset: downstream strobes and returns suppressed even with inputs active.
    repeat (2) @(posedge clk);
    #1;
    s1_read = 1'b1; m_read_data_valid = 1'b1;
    smp();
    check("rst_m_read", 64'(m_read), 64'(0));
    check("rst_m_write", 64'(m_write), 64'(0));
    check("rst_s0_rdv", 64'(s0_read_data_valid), 64'(0));
    check("rst_s1_rdv", 64'(s1_read_data_valid), 64'(0));
    s1_read = 1'b0; m_read_data_valid = 1'b0;
    rest = 1'b0;
    cyc();

    // Single s0 read, data two cycles after acceptance.
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    smp();
    check("t1_m_read", 64'(m_read), 64'(1));
    check("t1_m_address", 64'(m_address), 64'(32'h100));
    check("t1_s0_wait", 64'(s0_waitrequest), 64'(0));
    cyc(); s0_read = 1'b0;
    cyc();
    m_read_data_valid = 1'b1; m_read_data = 32'hDEADBEEF;
    smp();
    check("t1_s0_rdv", 64'(s0_read_data_valid), 64'(1));
    check("t1_s0_data", 64'(s0_read_data), 64'(32'hDEADBEEF));
    check("t1_s1_rdv", 64'(s1_read_data_valid), 64'(0));
    cyc(); m_read_data_valid = 1'b0;

    // Simultaneous reads: s1 first, then s0; returns route in issue order.
    set_req(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    smp();
    check("t2_first_addr", 64'(m_address), 64'(32'h300));
    check("t2_s1_wait", 64'(s1_waitrequest), 64'(0));
    check("t2_s0_wait", 64'(s0_waitrequest), 64'(1));
    cyc(); s1_read = 1'b0;
    smp();
    check("t2_second_addr", 64'(m_address), 64'(32'h200));
    check("t2_s0_wait2", 64'(s0_waitrequest), 64'(0));
    cyc(); s0_read = 1'b0;
    m_read_data_valid = 1'b1; m_read_data = 32'h11;
    smp();
    check("t2_ret1_route", 64'({s1_read_data_valid, s0_read_data_valid}), 64'(2'b10));
    cyc(); m_read_data = 32'h22;
    smp();
    check("t2_ret2_route", 64'({s1_read_data_valid, s0_read_data_valid}), 64'(2'b01));
    check("t2_ret2_data", 64'(s0_read_data), 64'(32'h22));
    cyc(); m_read_data_valid = 1'b0;

    // Stalled s0 read holds the grant while s1 waits with a write.
    set_req(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    m_waitrequest = 1'b1;
    smp();
    check("t3_stall_addr0", 64'(m_address), 64'(32'h400));
    check("t3_s0_wait", 64'(s0_waitrequest), 64'(1));
    cyc();
    set_req(1, 1'b0, 1'b1, 32'h500, 32'hCAFE, 4'h3);
    for (int i = 0; i < 2; i++) begin
      smp();
      check("t3_lock_addr", 64'(m_address), 64'(32'h400));
      check("t3_lock_no_write", 64'(m_write), 64'(0));
      check("t3_s1_wait", 64'(s1_waitrequest), 64'(1));
      cyc();
    end
    m_waitrequest = 1'b0;
    smp();
    check("t3_accept_addr", 64'(m_address), 64'(32'h400));
    check("t3_accept_s0", 64'(s0_waitrequest), 64'(0));
    check("t3_accept_s1_wait", 64'(s1_waitrequest), 64'(1));
    cyc(); s0_read = 1'b0;
    smp();
    check("t3_write_issue", 64'({m_write, m_address, m_write_data}), 64'({1'b1, 32'h500, 32'hCAFE}));
    check("t3_s1_wait_low", 64'(s1_waitrequest), 64'(0));
    cyc(); s1_write = 1'b0;
    m_read_data_valid = 1'b1; m_read_data = 32'h33;
    smp();
    check("t3_ret_s0", 64'(s0_read_data_valid), 64'(1));
    cyc(); m_read_data_valid = 1'b0;

    // Fill the tag FIFO, stall the fifth read, release it with a same-cycle return.
    s0_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0_address = 32'h1000 + 32'(i * 4);
      smp();
      check("t4_fill_accept", 64'(s0_waitrequest), 64'(0));
      cyc();
    end
    s0_address = 32'h1010;
    smp();
    check("t4_full_wait", 64'(s0_waitrequest), 64'(1));
    check("t4_full_no_read", 64'(m_read), 64'(0));
    cyc();
    m_read_data_valid = 1'b1; m_read_data = 32'h44;
    smp();
    check("t4_popfree_read", 64'(m_read), 64'(1));
    check("t4_popfree_wait", 64'(s0_waitrequest), 64'(0));
    check("t4_popfree_rdv", 64'(s0_read_data_valid), 64'(1));
    cyc(); s0_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      check("t4_drain_rdv", 64'(s0_read_data_valid), 64'(1));
      cyc();
    end
    smp();
    check("t4_spurious_dropped", 64'({s0_read_data_valid, s1_read_data_valid}), 64'(0));
    cyc(); m_read_data_valid = 1'b0;

    // Continuous contention: fixed priority keeps s1, round-robin alternates from s1.
    set_req(0, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
`ifdef CORE_BUS_ARB_RR_EN
      exp_s1 = (i % 2 == 0);
`else
      exp_s1 = 1'b1;
`endif
      smp();
      check("t5_winner_addr", 64'(m_address), exp_s1 ? 64'(32'h700) : 64'(32'h600));
      cyc();
    end
    s0_read = 1'b0; s1_read = 1'b0;
    m_read_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef CORE_BUS_ARB_RR_EN
      exp_s1 = (i % 2 == 0);
`else
      exp_s1 = 1'b1;
`endif
      smp();
      check("t5_return_route", 64'({s1_read_data_valid, s0_read_data_valid}),
            64'({exp_s1, ~exp_s1}));
      cyc();
    end
    m_read_data_valid = 1'b0;

    // Reset in LOCK1 with two reads in flight: later return is dropped.
    set_req(0, 1'b1, 1'b0, 32'h800, 32'h0, 4'hF);
    cyc(); s0_address = 32'h804;
    cyc(); s0_read = 1'b0;
    set_req(1, 1'b1, 1'b0, 32'h900, 32'h0, 4'hF);
    m_waitrequest = 1'b1;
    cyc();
    smp();
    check("t6_lock1_addr", 64'(m_address), 64'(32'h900));
    rest = 1'b1;
    #2;
    check("t6_m_read_in_reset", 64'(m_read), 64'(0));
    cyc();
    s1_read = 1'b0; m_waitrequest = 1'b0; rest = 1'b0;
    m_read_data_valid = 1'b1;
    smp();
    check("t6_stale_dropped", 64'({s0_read_data_valid, s1_read_data_valid}), 64'(0));
    cyc(); m_read_data_valid = 1'b0;
    set_req(1, 1'b1, 1'b0, 32'hA00, 32'h0, 4'hF);
    smp();
    check("t6_idle_grant", 64'({m_read, s1_waitrequest}), 64'(2'b10));
    cyc(); s1_read = 1'b0;
    m_read_data_valid = 1'b1; m_read_data = 32'h55;
    smp();
    check("t6_fresh_route", 64'({s1_read_data_valid, s0_read_data_valid}), 64'(2'b10));
    cyc(); m_read_data_valid = 1'b0;

    // Randomized run against the scoreboard.
    acc_cnt = 0;
    mem_on  = 1'b1;
    mon_on  = 1'b1;
    fork
      memory();
      monitor();
    join_none
    fork
      driver(0, 60);
      driver(1, 60);
    join
    waited = 0;
    while ((pend.size() != 0 || rq0.size() != 0 || rq1.size() != 0) && waited < 500) begin
      cyc();
      waited++;
    end
    if (waited >= 500) fail_now("drain_timeout");
    mem_on = 1'b0;
    repeat (2) cyc();
    mon_on = 1'b0;
    repeat (3) cyc();
    check("mq_drained", 64'(mq.size()), 64'(0));
    check("rq0_drained", 64'(rq0.size()), 64'(0));
    check("rq1_drained", 64'(rq1.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
